intt_scale_unpack: RTL and testbench

//  Downstream stage of the flat INTT core. Captures one D-coefficient flat result bus,

---
 rtl/ntt_pkg.sv | 28 ++
 rtl/mod_q_reduce.sv | 31 +++
 rtl/intt_scale_unpack.sv | 120 ++++++++++++
 tb/tb_intt_scale_unpack.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the Q = 65537 NTT/INTT datapath.
package ntt_pkg;

  localparam int unsigned Q     = 65537;
  localparam int unsigned W     = 17;
  localparam int unsigned D     = 16;
  localparam int unsigned N_INV = 61441;
  localparam int unsigned IW    = $clog2(D);
  localparam int unsigned PW    = 2 * W;

  typedef logic [W-1:0]  coef_t;
  typedef logic [PW-1:0] prod_t;
  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RED,
    OUT
  } state_t;

  typedef struct packed {
    coef_t data;
    idx_t  index;
    logic  last;
  } beat_t;

endpackage

// File: rtl/mod_q_reduce.sv
// Combinational reduction of a 2W-bit value modulo Q = 2^16 + 1.
// Uses 2^16 == -1 (mod Q): x = x2*2^32 + x1*2^16 + x0 == x0 - x1 + x2.
module mod_q_reduce
  import ntt_pkg::*;
(
  input  prod_t x,
  output coef_t r_c
);

  localparam int unsigned HW = W - 1;
  localparam int unsigned SW = W + 1;

  logic [HW-1:0] x0;
  logic [HW-1:0] x1;
  logic [PW-2*HW-1:0] x2;
  logic [SW-1:0] s;
  logic [SW-1:0] s1;
  logic [SW-1:0] s2;

  // Offset by Q keeps the folded sum non-negative; two conditional subtracts finish it.
  always_comb begin
    x0 = x[HW-1:0];
    x1 = x[2*HW-1:HW];
    x2 = x[PW-1:2*HW];
    s  = SW'(x0) + SW'(x2) + SW'(Q) - SW'(x1);
    s1 = (s  >= SW'(Q)) ? s  - SW'(Q) : s;
    s2 = (s1 >= SW'(Q)) ? s1 - SW'(Q) : s1;
    r_c = W'(s2);
  end

endmodule

// File: rtl/intt_scale_unpack.sv
// Captures a flat INTT result, scales each coefficient by D^-1 mod Q and streams it out.
// Scaling by N_INV is enabled by INTT_SCALE_EN; otherwise coefficients are only reduced mod Q.
module intt_scale_unpack
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [D*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
  output logic            busy
);

  state_t state_q, state_d;
  idx_t   idx_q, idx_d;
  coef_t  coef_q [D];
  coef_t  coef_d [D];
  prod_t  prod_q, prod_d;
  beat_t  beat_q, beat_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   busy_q, busy_d;
  coef_t  red_c;

  mod_q_reduce u_reduce (
    .x   (prod_q),
    .r_c (red_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coef_d      = coef_q;
    prod_d      = prod_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int unsigned i = 0; i < D; i++) begin
            coef_d[i] = in_data[W*i +: W];
          end
          idx_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
`ifdef INTT_SCALE_EN
        prod_d = prod_t'(coef_q[idx_q]) * prod_t'(N_INV);
`else
        prod_d = prod_t'(coef_q[idx_q]);
`endif
        state_d = RED;
      end
      RED: begin
        beat_d.data  = red_c;
        beat_d.index = idx_q;
        beat_d.last  = (idx_q == IW'(D - 1));
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == IW'(D - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = MUL;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        coef_q[i] <= '0;
      end
      prod_q      <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coef_q      <= coef_d;
      prod_q      <= prod_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = beat_q.data;
  assign out_index = beat_q.index;
  assign out_last  = beat_q.last;
  assign busy      = busy_q;

endmodule

// File: tb/tb_intt_scale_unpack.sv
// Directed bench for intt_scale_unpack; expectations follow the INTT_SCALE_EN build setting.
module tb_intt_scale_unpack;
  import ntt_pkg::*;

`ifdef INTT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  typedef struct {
    logic [D-1:0][W-1:0] coef;
    logic [D-1:0][W-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [D*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad   = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;

  intt_scale_unpack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the stream ends.
  task automatic run_stream(input vec_t v, input int stall_idx, input int stall_n,
                            input int pulse_cyc);
    int cyc, k, left, extra, guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before", 64'(in_ready), 64'd1);
    in_data   = v.coef;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
    cyc   = 1;
    k     = 0;
    left  = stall_n;
    extra = 0;
    while (k < D && cyc < 300) begin
      in_valid = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) begin
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        chk("busy_mid", 64'(busy), 64'd1);
      end
      if (out_valid) begin
        if (k == stall_idx && left > 0) begin
          out_ready = 1'b0;
          chk($sformatf("stall_data[%0d]", k), 64'(out_data), 64'(v.exp[k]));
          chk($sformatf("stall_index[%0d]", k), 64'(out_index), 64'(k));
          left--;
          extra++;
        end else begin
          out_ready = 1'b1;
          chk($sformatf("data[%0d]", k), 64'(out_data), 64'(v.exp[k]));
          chk($sformatf("index[%0d]", k), 64'(out_index), 64'(k));
          chk($sformatf("last[%0d]", k), 64'(out_last), 64'(k == D - 1));
          chk($sformatf("beat_cycle[%0d]", k), 64'(cyc), 64'(3 * (k + 1) + extra));
          k++;
        end
      end else if (left > 0 && left < stall_n) begin
        chk("stall_valid_drop", 64'd0, 64'd1);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("beats", 64'(k), 64'(D));
    chk("done_cycle", 64'(cyc), 64'(3 * D + 1 + extra));
    chk("in_ready_after", 64'(in_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("out_valid_after", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int guard;

    for (int i = 0; i < D; i++) begin
      vecs[0].coef[i] = W'(1);
      vecs[0].exp[i]  = SCALE ? W'(61441) : W'(1);
      vecs[1].coef[i] = W'(16 * i);
      vecs[1].exp[i]  = SCALE ? W'(i) : W'(16 * i);
      vecs[2].coef[i] = W'(0);
      vecs[2].exp[i]  = W'(0);
      vecs[3].coef[i] = (i % 2 == 0) ? W'(5) : W'(65540);
      vecs[3].exp[i]  = (i % 2 == 0) ? (SCALE ? W'(45057) : W'(5))
                                     : (SCALE ? W'(53249) : W'(3));
    end
    vecs[2].coef[0] = W'(65536);
    vecs[2].exp[0]  = SCALE ? W'(4096) : W'(65536);
    vecs[2].coef[1] = W'(131071);
    vecs[2].exp[1]  = SCALE ? W'(12288) : W'(65534);
    vecs[2].coef[2] = W'(65537);
    vecs[2].exp[2]  = W'(0);
    vecs[2].coef[3] = W'(131070);
    vecs[2].exp[3]  = SCALE ? W'(16384) : W'(65533);

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int t = 0; t < 4; t++) begin
      run_stream(vecs[t], -1, 0, -1);
    end
    run_stream(vecs[1], 3, 5, -1);
    run_stream(vecs[0], -1, 0, 20);

    // Reset while index 7 is on the output.
    in_data   = vecs[2].coef;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!(out_valid && out_index == IW'(7)) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_index7", 64'(out_valid && out_index == IW'(7)), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_index", 64'(out_index), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
    run_stream(vecs[1], -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
